// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 core constants: ALU op codes, forward selects, datapath width
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32 ALU with zero flag
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic lt;

    always_comb begin
        lt     = ($signed(a) < $signed(b));
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - EX stage: forwarding, ALU, beq resolve, wrong-path squash, EX/MEM register
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int SQUASH_N = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    localparam int SQW = (SQUASH_N < 1) ? 1 : $clog2(SQUASH_N + 1);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [SQW-1:0]  sq_cnt;
    logic            kill;

    // ALUResultM doubles as the MEM-stage forwarding source.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a      (src_a),
        .b      (src_b),
        .ctrl   (ALUControlE),
        .result (alu_result),
        .zero   (zero)
    );

    // A beq sitting in a squash slot is itself wrong-path and must not redirect fetch.
    assign kill      = (sq_cnt != '0);
    assign PCSrcE    = BranchE & zero & ~kill;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_cnt <= '0;
        end else if (PCSrcE) begin
            sq_cnt <= SQW'(SQUASH_N);
        end else if (sq_cnt != '0) begin
            sq_cnt <= sq_cnt - SQW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE & ~kill;
            MemWriteM  <= MemWriteE & ~kill;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed and randomized self-checking bench for execute_cycle
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int total = 0;
    int bad   = 0;

    // reference state: previous cycle's ALU result and remaining wrong-path slots
    logic [31:0] m_alu_m;
    int          m_cnt;
    int          n_taken;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32), .SQUASH_N(2)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a + ~b + 32'd1;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd5:    r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic set_in(input logic rw, input logic alusrc, input logic mw, input logic rs,
                          input logic br, input logic [2:0] op, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] resw);
        RegWriteE = rw; ALUSrcE = alusrc; MemWriteE = mw; ResultSrcE = rs; BranchE = br;
        ALUControlE = op; RD1_E = rd1; RD2_E = rd2; Imm_Ext_E = imm; RD_E = rd;
        PCE = pc; PCPlus4E = pc + 32'd4; ForwardAE = fa; ForwardBE = fb; ResultW = resw;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return m_alu_m;
        return rf;
    endfunction

    // Check the combinational branch outputs, clock once, then check the EX/MEM register.
    task automatic run_cycle();
        logic [31:0] a, wd, b, res;
        logic        kill, taken;
        #1;
        a     = pick(ForwardAE, RD1_E);
        wd    = pick(ForwardBE, RD2_E);
        b     = ALUSrcE ? Imm_Ext_E : wd;
        res   = ref_alu(ALUControlE, a, b);
        kill  = (m_cnt != 0);
        taken = BranchE && (res == 32'd0) && !kill;
        chk("pcsrc", {31'd0, PCSrcE}, {31'd0, taken});
        chk("pctarget", PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        #1;
        if (taken) begin
            m_cnt = 2;
            n_taken++;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
        m_alu_m = res;
        chk("regwrite_m", {31'd0, RegWriteM}, {31'd0, RegWriteE && !kill});
        chk("memwrite_m", {31'd0, MemWriteM}, {31'd0, MemWriteE && !kill});
        chk("resultsrc_m", {31'd0, ResultSrcM}, {31'd0, ResultSrcE});
        chk("rd_m", {27'd0, RD_M}, {27'd0, RD_E});
        chk("aluresult_m", ALUResultM, res);
        chk("writedata_m", WriteDataM, wd);
        chk("pcplus4_m", PCPlus4M, PCPlus4E);
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, "_rw"}, {31'd0, RegWriteM}, 32'd0);
        chk({tag, "_mw"}, {31'd0, MemWriteM}, 32'd0);
        chk({tag, "_rs"}, {31'd0, ResultSrcM}, 32'd0);
        chk({tag, "_rd"}, {27'd0, RD_M}, 32'd0);
        chk({tag, "_alu"}, ALUResultM, 32'd0);
        chk({tag, "_wd"}, WriteDataM, 32'd0);
        chk({tag, "_pc4"}, PCPlus4M, 32'd0);
    endtask

    initial begin
        logic [31:0] r1, r2;
        logic [2:0]  ops [6];
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd3; ops[4] = 3'd5; ops[5] = 3'd7;
        n_taken = 0;
        rst = 1'b1;
        set_in(1, 0, 1, 1, 0, 3'd0, 32'h11, 32'h22, 32'h33, 5'd7, 32'h40, 2'd0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_m_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        m_alu_m = 32'd0;
        m_cnt   = 0;

        // forwarding from MEM
        set_in(1, 0, 0, 0, 0, 3'd0, 32'd5, 32'd0, 32'd0, 5'd3, 32'h0, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t1_pre", ALUResultM, 32'd5);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 3'd0, 32'h99, 32'd7, 32'd0, 5'd9, 32'h4, 2'd2, 2'd0, 32'd0);
        run_cycle();
        chk("t1_sum", ALUResultM, 32'd12);
        chk("t1_rd", {27'd0, RD_M}, 32'd9);

        // store with WB-forwarded data
        @(negedge clk);
        set_in(0, 1, 1, 0, 0, 3'd0, 32'h40, 32'h11, 32'd8, 5'd0, 32'h8, 2'd0, 2'd1, 32'hAB);
        run_cycle();
        chk("t2_wd", WriteDataM, 32'hAB);
        chk("t2_mw", {31'd0, MemWriteM}, 32'd1);
        chk("t2_alu", ALUResultM, 32'h48);

        // taken beq, squash window, beq inside the window, then resumption
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 3'd1, 32'd3, 32'd3, 32'h20, 5'd0, 32'h100, 2'd0, 2'd0, 32'd0);
        #1;
        chk("t3_pcsrc", {31'd0, PCSrcE}, 32'd1);
        chk("t3_target", PCTargetE, 32'h120);
        run_cycle();
        @(negedge clk);
        set_in(1, 0, 1, 0, 0, 3'd0, 32'd1, 32'd2, 32'd0, 5'd4, 32'h104, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t3_kill1", {31'd0, RegWriteM}, 32'd0);
        chk("t3_kill1_mw", {31'd0, MemWriteM}, 32'd0);
        @(negedge clk);
        set_in(1, 0, 0, 0, 1, 3'd1, 32'd9, 32'd9, 32'h40, 5'd5, 32'h108, 2'd0, 2'd0, 32'd0);
        #1;
        chk("t4_pcsrc", {31'd0, PCSrcE}, 32'd0);
        run_cycle();
        chk("t3_kill2", {31'd0, RegWriteM}, 32'd0);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 3'd0, 32'd1, 32'd2, 32'd0, 5'd6, 32'h120, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t3_resume", {31'd0, RegWriteM}, 32'd1);

        // ALU corner cases
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 3'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd1, 32'h0, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t5_slt", ALUResultM, 32'd1);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 3'd1, 32'd0, 32'd1, 32'd0, 5'd1, 32'h0, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t5_sub", ALUResultM, 32'hFFFFFFFF);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 3'd7, 32'd5, 32'd6, 32'd0, 5'd1, 32'h0, 2'd0, 2'd0, 32'd0);
        run_cycle();
        chk("t5_bad_op", ALUResultM, 32'd0);

        // async reset in the middle of a squash window
        @(negedge clk);
        set_in(0, 0, 0, 0, 1, 3'd1, 32'd4, 32'd4, 32'h10, 5'd0, 32'h200, 2'd0, 2'd0, 32'd0);
        run_cycle();
        @(negedge clk);
        set_in(1, 0, 1, 1, 0, 3'd0, 32'd1, 32'd1, 32'd0, 5'd8, 32'h204, 2'd0, 2'd0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk_m_zero("t6_async");
        m_alu_m = 32'd0;
        m_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
        run_cycle();
        chk("t6_after", {31'd0, RegWriteM}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            set_in($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                   ops[$urandom_range(0, 5)], r1, r2, $urandom, 5'($urandom),
                   $urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 0) ? r1 : $urandom);
            if (BranchE && $urandom_range(0, 1) == 0) begin
                ALUControlE = 3'd1;
                ALUSrcE     = 1'b0;
            end
            run_cycle();
        end
        chk("taken_seen", {31'd0, n_taken > 3}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
